multicycle_controller: RTL

Main control FSM of the RV32I multi-cycle core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the instruction-register load enable (`ir_write`) and consumes the latched instruction fields that register produces. All datapath mux selects, write enables and ALU control come from this block. It is a Moore FSM, apart from the ALU/immediate decode and the branch PC-write condition.

---
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller.sv | 124 ++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: latched instruction fields and ALU flags in,
// mux selects, write strobes and ALU control out.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       neg;
  logic       ir_write;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctl;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, funct7b5, zero, neg,
    output ir_write, pc_write, adr_src, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_ctl, result_src, imm_src, state
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, neg,
    input  ir_write, pc_write, adr_src, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_ctl, result_src, imm_src, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// RV32I multi-cycle control FSM: Moore state outputs plus combinational
// ALU/immediate decode and the branch-taken PC write.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADR = 4'd2, MEM_READ = 4'd3,
    MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7,
    ALU_WB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, JALR = 4'd11,
    JALR_PC = 4'd12, LUI = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_OR = 3'd3, ALU_XOR = 3'd4, ALU_SLT = 3'd5;

  state_t state_q, state_d;

  logic       ir_write, pc_write, adr_src, mem_write, reg_write, taken;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_ctl, imm_src;

  // sub_ok is only set for R-type, so an I-type with Inst[30]=1 stays add
  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  alu_dec = sub_ok ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b100:  alu_dec = ALU_XOR;
      3'b010:  alu_dec = ALU_SLT;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] imm_dec(input logic [6:0] op);
    case (op)
      OP_STORE: imm_dec = 3'd1;
      OP_BR:    imm_dec = 3'd2;
      OP_JAL:   imm_dec = 3'd3;
      OP_LUI:   imm_dec = 3'd4;
      default:  imm_dec = 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE:
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = MEM_ADR;
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_BR:             state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          default:           state_d = FETCH;
        endcase
      MEM_ADR:  state_d = (bus.opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
      MEM_READ: state_d = MEM_WB;
      EXEC_R, EXEC_I, JAL, JALR_PC: state_d = ALU_WB;
      JALR:     state_d = JALR_PC;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    case (bus.funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = !bus.zero;
      3'b100:  taken = bus.neg;
      3'b101:  taken = !bus.neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ir_write = 1'b0; pc_write = 1'b0; adr_src = 1'b0;
    mem_write = 1'b0; reg_write = 1'b0;
    alu_src_a = 2'b00; alu_src_b = 2'b00; alu_ctl = ALU_ADD;
    result_src = 2'b00;
    imm_src = (state_q == FETCH) ? 3'd0 : imm_dec(bus.opcode);
    case (state_q)
      FETCH:     begin ir_write = 1'b1; pc_write = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; end
      DECODE:    begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      MEM_ADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      MEM_READ:  adr_src = 1'b1;
      MEM_WB:    begin reg_write = 1'b1; result_src = 2'b01; end
      MEM_WRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
      EXEC_R:    begin alu_src_a = 2'b10; alu_ctl = alu_dec(bus.funct3, bus.funct7b5); end
      EXEC_I:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_ctl = alu_dec(bus.funct3, 1'b0); end
      ALU_WB:    reg_write = 1'b1;
      BRANCH:    begin alu_src_a = 2'b10; alu_ctl = ALU_SUB; pc_write = taken; end
      JAL, JALR_PC: begin pc_write = 1'b1; alu_src_a = 2'b01; alu_src_b = 2'b10; end
      JALR:      begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      LUI:       begin imm_src = 3'd4; result_src = 2'b11; reg_write = 1'b1; end
      default:   ;
    endcase
  end

  // strobes are suppressed during reset so an aborted instruction writes nothing
  assign bus.ir_write   = ir_write  & ~rst;
  assign bus.pc_write   = pc_write  & ~rst;
  assign bus.mem_write  = mem_write & ~rst;
  assign bus.reg_write  = reg_write & ~rst;
  assign bus.adr_src    = adr_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_ctl    = alu_ctl;
  assign bus.result_src = result_src;
  assign bus.imm_src    = imm_src;
  assign bus.state      = state_q;
endmodule
